// File: rtl/sram_cluster_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_cluster_writer_if
// Description : Command / data-stream / SRAM-write bundle for the SRAM
//               cluster write controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_cluster_writer_if #(
  parameter int SRAM_NUM   = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
);
  localparam int SEL_W = (SRAM_NUM > 1) ? $clog2(SRAM_NUM) : 1;

  // Burst command
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [SEL_W-1:0]      cmd_sram;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;

  // Data stream
  logic                  data_valid;
  logic                  data_ready;
  logic [DATA_WIDTH-1:0] data;

  // SRAM write side
  logic [SRAM_NUM-1:0]   w_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  // Status
  logic                  busy;
  logic                  done;
  logic                  err;

  // Command/data source and write-side observer
  modport master (
    output cmd_valid, cmd_sram, cmd_addr, cmd_len,
    output data_valid, data,
    input  cmd_ready, data_ready,
    input  w_en, w_addr, w_data,
    input  busy, done, err
  );

  // The write controller itself
  modport slave (
    input  cmd_valid, cmd_sram, cmd_addr, cmd_len,
    input  data_valid, data,
    output cmd_ready, data_ready,
    output w_en, w_addr, w_data,
    output busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/sram_cluster_writer.sv
`default_nettype none
// ============================================================================
// Module      : sram_cluster_writer
// Description : Burst write controller for the SRAM cluster. Accepts a
//               command (target SRAM, start address, length) and a stream of
//               data words, and emits registered one-hot write strobes with
//               an auto-incrementing, wrapping address.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_cluster_writer #(
  parameter int SRAM_NUM   = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64
) (
  input  wire                 clock,
  input  wire                 reset,   // asynchronous, active-low
  sram_cluster_writer_if.slave bus
);
  localparam int SEL_W = (SRAM_NUM > 1) ? $clog2(SRAM_NUM) : 1;
  localparam logic [SRAM_NUM-1:0] c_one_hot_base = {{(SRAM_NUM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SEL_W-1:0]      r_sel;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic                  r_bad;

  logic [SRAM_NUM-1:0]   r_w_en;
  logic [ADDR_WIDTH-1:0] r_w_addr;
  logic [DATA_WIDTH-1:0] r_w_data;

  logic w_cmd_ready;
  logic w_data_ready;
  logic w_busy;
  logic w_done;
  logic w_err;
  logic w_cmd_fire;
  logic w_word_fire;
  logic w_cmd_bad;

  // An out-of-range select is flagged so the burst still drains its words
  assign w_cmd_bad   = (int'(bus.cmd_sram) >= SRAM_NUM);
  assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
  assign w_word_fire = bus.data_valid && w_data_ready;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and state-decoded handshake/status outputs
  always_comb begin
    w_state_next = r_state;
    w_cmd_ready  = 1'b0;
    w_data_ready = 1'b0;
    w_busy       = 1'b1;
    w_done       = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        w_busy      = 1'b0;
        if (bus.cmd_valid) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_data_ready = 1'b1;
        if (bus.data_valid && (r_remaining == '0)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_err        = r_bad;
        w_state_next = S_IDLE;
      end
      default: begin
        w_busy       = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Burst context: latched on command, advanced once per accepted word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sel       <= '0;
      r_addr      <= '0;
      r_remaining <= '0;
      r_bad       <= 1'b0;
    end else if (w_cmd_fire) begin
      r_sel       <= bus.cmd_sram;
      r_addr      <= bus.cmd_addr;
      r_remaining <= bus.cmd_len;
      r_bad       <= w_cmd_bad;
    end else if (w_word_fire) begin
      r_addr <= r_addr + 1'b1;
      if (r_remaining != '0) begin
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  // Registered SRAM write port; address/data hold when no word is written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_w_en   <= '0;
      r_w_addr <= '0;
      r_w_data <= '0;
    end else begin
      r_w_en <= '0;
      if (w_word_fire) begin
        r_w_en   <= r_bad ? '0 : (c_one_hot_base << r_sel);
        r_w_addr <= r_addr;
        r_w_data <= bus.data;
      end
    end
  end

  assign bus.cmd_ready  = w_cmd_ready;
  assign bus.data_ready = w_data_ready;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err        = w_err;
  assign bus.w_en       = r_w_en;
  assign bus.w_addr     = r_w_addr;
  assign bus.w_data     = r_w_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_cluster_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_cluster_writer
// Description : Directed self-checking bench for sram_cluster_writer. A
//               16-SRAM instance carries most bursts; a 12-SRAM instance
//               covers the out-of-range target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_cluster_writer;
  logic clock;
  logic reset;

  int n_checks;
  int n_errors;

  sram_cluster_writer_if #(.SRAM_NUM(16), .ADDR_WIDTH(8), .DATA_WIDTH(64)) bus  ();
  sram_cluster_writer_if #(.SRAM_NUM(12), .ADDR_WIDTH(8), .DATA_WIDTH(64)) bus2 ();

  sram_cluster_writer #(.SRAM_NUM(16), .ADDR_WIDTH(8), .DATA_WIDTH(64)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  sram_cluster_writer #(.SRAM_NUM(12), .ADDR_WIDTH(8), .DATA_WIDTH(64)) u_dut12 (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts and reports
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  logic [7:0] exp_addr [4];
  logic       pat [6];

  initial begin
    int k;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus.cmd_valid  = 1'b0; bus.cmd_sram  = '0; bus.cmd_addr  = '0; bus.cmd_len  = '0;
    bus.data_valid = 1'b0; bus.data      = '0;
    bus2.cmd_valid = 1'b0; bus2.cmd_sram = '0; bus2.cmd_addr = '0; bus2.cmd_len = '0;
    bus2.data_valid = 1'b0; bus2.data    = '0;
    step(); step();

    // Reset state
    check("rst_w_en",       64'(bus.w_en), 64'h0);
    check("rst_w_addr",     64'(bus.w_addr), 64'h0);
    check("rst_w_data",     bus.w_data, 64'h0);
    check("rst_done",       64'(bus.done), 64'h0);
    check("rst_err",        64'(bus.err), 64'h0);
    check("rst_busy",       64'(bus.busy), 64'h0);
    check("rst_data_ready", 64'(bus.data_ready), 64'h0);
    check("rst_cmd_ready",  64'(bus.cmd_ready), 64'h1);
    reset = 1'b1;
    step();

    // data_valid while idle is ignored
    bus.data_valid = 1'b1; bus.data = 64'h1111;
    step();
    check("idle_dv_w_en", 64'(bus.w_en), 64'h0);
    check("idle_dv_busy", 64'(bus.busy), 64'h0);
    bus.data_valid = 1'b0;

    // Single word
    bus.cmd_valid = 1'b1; bus.cmd_sram = 4'd3; bus.cmd_addr = 8'h10; bus.cmd_len = 8'd0;
    step();
    check("sw_cmd_ready_T1",  64'(bus.cmd_ready), 64'h0);
    check("sw_data_ready_T1", 64'(bus.data_ready), 64'h1);
    check("sw_busy_T1",       64'(bus.busy), 64'h1);
    bus.cmd_valid = 1'b0; bus.data_valid = 1'b1; bus.data = 64'hDEADBEEF;
    step();
    check("sw_w_en",   64'(bus.w_en), 64'h0008);
    check("sw_w_addr", 64'(bus.w_addr), 64'h10);
    check("sw_w_data", bus.w_data, 64'hDEADBEEF);
    check("sw_done",   64'(bus.done), 64'h1);
    check("sw_err",    64'(bus.err), 64'h0);
    check("sw_cmd_ready_T2", 64'(bus.cmd_ready), 64'h0);
    bus.data_valid = 1'b0;
    step();
    check("sw_cmd_ready_T3", 64'(bus.cmd_ready), 64'h1);
    check("sw_done_T3",      64'(bus.done), 64'h0);
    check("sw_w_en_T3",      64'(bus.w_en), 64'h0);

    // Back-to-back burst into SRAM 15
    bus.cmd_valid = 1'b1; bus.cmd_sram = 4'd15; bus.cmd_addr = 8'h00; bus.cmd_len = 8'd3;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.data_valid = 1'b1; bus.data = 64'h100 + 64'(i);
      step();
      check("b2b_w_en",   64'(bus.w_en), 64'h8000);
      check("b2b_w_addr", 64'(bus.w_addr), 64'(i));
      check("b2b_w_data", bus.w_data, 64'h100 + 64'(i));
      check("b2b_done",   64'(bus.done), (i == 3) ? 64'h1 : 64'h0);
    end
    bus.data_valid = 1'b0;
    step();
    check("b2b_w_en_after",   64'(bus.w_en), 64'h0);
    check("b2b_w_addr_hold",  64'(bus.w_addr), 64'h3);
    check("b2b_cmd_ready",    64'(bus.cmd_ready), 64'h1);

    // Address wrap with bubbles, SRAM 5
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
    bus.cmd_valid = 1'b1; bus.cmd_sram = 4'd5; bus.cmd_addr = 8'hFE; bus.cmd_len = 8'd3;
    step();
    bus.cmd_valid = 1'b0;
    k = 0;
    for (int j = 0; j < 6; j++) begin
      bus.data_valid = pat[j]; bus.data = 64'h200 + 64'(j);
      step();
      if (pat[j]) begin
        check("wrap_w_en",   64'(bus.w_en), 64'h0020);
        check("wrap_w_addr", 64'(bus.w_addr), 64'(exp_addr[k]));
        check("wrap_w_data", bus.w_data, 64'h200 + 64'(j));
        k++;
        check("wrap_done",   64'(bus.done), (k == 4) ? 64'h1 : 64'h0);
      end else begin
        check("wrap_bubble_w_en",   64'(bus.w_en), 64'h0);
        check("wrap_bubble_w_addr", 64'(bus.w_addr), 64'(exp_addr[k-1]));
        check("wrap_bubble_done",   64'(bus.done), 64'h0);
      end
    end
    bus.data_valid = 1'b0;
    step();
    check("wrap_cmd_ready", 64'(bus.cmd_ready), 64'h1);

    // Invalid target on the 12-SRAM instance
    bus2.cmd_valid = 1'b1; bus2.cmd_sram = 4'd13; bus2.cmd_addr = 8'h08; bus2.cmd_len = 8'd1;
    step();
    bus2.cmd_valid = 1'b0; bus2.data_valid = 1'b1; bus2.data = 64'hA0;
    step();
    check("bad_w_en_0", 64'(bus2.w_en), 64'h0);
    check("bad_done_0", 64'(bus2.done), 64'h0);
    check("bad_dready", 64'(bus2.data_ready), 64'h1);
    bus2.data = 64'hA1;
    step();
    check("bad_w_en_1", 64'(bus2.w_en), 64'h0);
    check("bad_done_1", 64'(bus2.done), 64'h1);
    check("bad_err_1",  64'(bus2.err), 64'h1);
    bus2.data_valid = 1'b0;
    step();
    check("bad_cmd_ready", 64'(bus2.cmd_ready), 64'h1);
    check("bad_err_clr",   64'(bus2.err), 64'h0);
    bus2.cmd_valid = 1'b1; bus2.cmd_sram = 4'd2; bus2.cmd_addr = 8'h05; bus2.cmd_len = 8'd0;
    step();
    bus2.cmd_valid = 1'b0; bus2.data_valid = 1'b1; bus2.data = 64'hA2;
    step();
    check("bad_next_w_en",   64'(bus2.w_en), 64'h004);
    check("bad_next_w_addr", 64'(bus2.w_addr), 64'h05);
    check("bad_next_err",    64'(bus2.err), 64'h0);
    check("bad_next_done",   64'(bus2.done), 64'h1);
    bus2.data_valid = 1'b0;
    step();

    // Reset mid-burst
    bus.cmd_valid = 1'b1; bus.cmd_sram = 4'd6; bus.cmd_addr = 8'h20; bus.cmd_len = 8'd7;
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.data_valid = 1'b1; bus.data = 64'h300 + 64'(i);
      step();
    end
    check("mid_w_en_pre", 64'(bus.w_en), 64'h0040);
    #2 reset = 1'b0;
    #1;
    check("mid_w_en_async",      64'(bus.w_en), 64'h0);
    check("mid_busy_async",      64'(bus.busy), 64'h0);
    check("mid_cmd_ready_async", 64'(bus.cmd_ready), 64'h1);
    step();
    reset = 1'b1; bus.data_valid = 1'b0;
    step();
    check("mid_idle_w_en", 64'(bus.w_en), 64'h0);
    bus.cmd_valid = 1'b1; bus.cmd_sram = 4'd1; bus.cmd_addr = 8'h40; bus.cmd_len = 8'd0;
    step();
    bus.cmd_valid = 1'b0; bus.data_valid = 1'b1; bus.data = 64'h400;
    step();
    check("mid_new_w_en",   64'(bus.w_en), 64'h0002);
    check("mid_new_w_addr", 64'(bus.w_addr), 64'h40);
    check("mid_new_done",   64'(bus.done), 64'h1);
    bus.data_valid = 1'b0;
    step();

    // Command held high across a 2-word burst
    bus.cmd_valid = 1'b1; bus.cmd_sram = 4'd4; bus.cmd_addr = 8'h30; bus.cmd_len = 8'd1;
    step();
    check("hold_cmd_ready_w0", 64'(bus.cmd_ready), 64'h0);
    bus.data_valid = 1'b1; bus.data = 64'h500;
    step();
    check("hold_cmd_ready_w1", 64'(bus.cmd_ready), 64'h0);
    check("hold_w_en_0",       64'(bus.w_en), 64'h0010);
    check("hold_w_addr_0",     64'(bus.w_addr), 64'h30);
    bus.data = 64'h501;
    step();
    check("hold_cmd_ready_done", 64'(bus.cmd_ready), 64'h0);
    check("hold_done",           64'(bus.done), 64'h1);
    check("hold_w_en_1",         64'(bus.w_en), 64'h0010);
    check("hold_w_addr_1",       64'(bus.w_addr), 64'h31);
    bus.data_valid = 1'b0;
    bus.cmd_sram = 4'd7; bus.cmd_addr = 8'h50; bus.cmd_len = 8'd0;
    step();
    check("hold_idle_cmd_ready", 64'(bus.cmd_ready), 64'h1);
    check("hold_idle_busy",      64'(bus.busy), 64'h0);
    step();
    check("hold_acc_cmd_ready",  64'(bus.cmd_ready), 64'h0);
    check("hold_acc_data_ready", 64'(bus.data_ready), 64'h1);
    bus.cmd_valid = 1'b0; bus.data_valid = 1'b1; bus.data = 64'h600;
    step();
    check("hold2_w_en",   64'(bus.w_en), 64'h0080);
    check("hold2_w_addr", 64'(bus.w_addr), 64'h50);
    check("hold2_w_data", bus.w_data, 64'h600);
    check("hold2_done",   64'(bus.done), 64'h1);
    bus.data_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_cluster_writer.md
# sram_cluster_writer

Write-side controller for the SRAM cluster: accepts a burst command (target SRAM, start address, length) plus a stream of 64-bit data words, and drives registered write strobes into one of the cluster's SRAMs with an auto-incrementing address. It is the fill/configuration path for the table SRAMs. The SRAM read ports on the other side of the cluster only consume what this block has written.

## Interface

Parameters:
- `SRAM_NUM`, default 16: number of SRAMs in the cluster; the select width is `SEL_W = clog2(SRAM_NUM)` (4).
- `ADDR_WIDTH`, default 8: SRAM address width (256 entries).
- `DATA_WIDTH`, default 64: SRAM word width.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: burst command valid.
- `cmd_ready`  out  1: high only in IDLE.
- `cmd_sram`  in  SEL_W: target SRAM index.
- `cmd_addr`  in  ADDR_WIDTH: first write address.
- `cmd_len`  in  ADDR_WIDTH: word count minus 1 (0 = 1 word, 255 = 256 words).
- `data_valid`  in  1: data word valid.
- `data_ready`  out  1: high only in WRITE.
- `data`  in  DATA_WIDTH: data word.
- `w_en`  out  SRAM_NUM: one-hot write strobe, bit i drives SRAM i.
- `w_addr`  out  ADDR_WIDTH: shared write address.
- `w_data`  out  DATA_WIDTH: shared write data.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle pulse at burst completion.
- `err`  out  1: one-cycle pulse together with `done` if `cmd_sram >= SRAM_NUM`.

## Operation

- State machine IDLE → WRITE → DONE → IDLE.
  - IDLE → WRITE: on the `cmd_valid && cmd_ready` handshake. Latch `sel`, `addr`, `remaining = cmd_len`, and `bad = (cmd_sram >= SRAM_NUM)`.
  - WRITE: `data_ready = 1`. Each `data_valid` cycle is one accepted word.
    - Register `w_en = bad ? 0 : (1 << sel)`, `w_addr = addr`, `w_data = data`.
    - Then `addr <= addr + 1`, modulo 2^ADDR_WIDTH (address 255 wraps to 0 within the same SRAM).
    - If `remaining == 0`, go to DONE; otherwise `remaining <= remaining - 1`.
  - A cycle in WRITE with `data_valid = 0` is a bubble: `w_en = 0` next cycle and no state change. There is no timeout.
  - DONE: `done = 1` and `err = bad` for exactly one cycle, then IDLE. `cmd_ready = 0` in DONE, so a command presented in DONE is held off until IDLE.
- `w_en`, `w_addr` and `w_data` are registered.
  - `w_en` is zero in any cycle not directly following an accepted word.
  - `w_addr` and `w_data` hold their last value when `w_en = 0`.
- An invalid `cmd_sram` still consumes all `cmd_len + 1` words, so the stream stays aligned. It generates no strobes.
- `busy` is combinational from state: 1 in WRITE and DONE.

## Timing

- Reset values: state IDLE; `w_en = 0`, `w_addr = 0`, `w_data = 0`, `done = 0`, `err = 0`, `busy = 0`, `data_ready = 0`, `cmd_ready = 1` (from IDLE).
- Reset asserted mid-burst: the burst is dropped immediately (asynchronous) and no further strobes occur. After deassertion the block is in IDLE and the next command starts clean.
- Command accepted at cycle T: `data_ready = 1` from T+1. The earliest first word is accepted at T+1.
- Word accepted at cycle k: `w_en` bit asserted at k+1.
- Last word accepted at cycle L: state is DONE at L+1. The last `w_en`, `done` and `err` are all high at L+1, and `cmd_ready = 1` again at L+2.
- Throughput: one word per cycle. Minimum burst turnaround is N+3 cycles for N words (command, N words, DONE, back to IDLE).
- `data_valid` outside WRITE is ignored (`data_ready = 0`), and no word is consumed.

## Test plan

- **Single word:** cmd_sram=3, cmd_addr=0x10, cmd_len=0, data=0xDEADBEEF at T+1 → at T+2: `w_en = 0x0008`, `w_addr = 0x10`, `w_data = 0xDEADBEEF`, `done = 1`, `err = 0`; `cmd_ready = 1` at T+3.
- **Back-to-back burst:** cmd_sram=15, cmd_addr=0x00, cmd_len=3, four consecutive words → `w_en = 0x8000` for 4 consecutive cycles with `w_addr` 0,1,2,3; `done` coincides with the 4th strobe.
- **Wrap and bubbles:** cmd_addr=0xFE, cmd_len=3, `data_valid` toggled 1,0,1,1,0,1 → strobes only after valid cycles, addresses 0xFE, 0xFF, 0x00, 0x01; `done` with the 4th strobe.
- **Invalid target:** SRAM_NUM=12, cmd_sram=13, cmd_len=1, two words → both words consumed; `w_en` stays 0; `done = 1` and `err = 1` together; the next command is accepted normally.
- **Reset mid-burst:** cmd_len=7, reset asserted after 3 words → `w_en = 0`, `busy = 0`, `cmd_ready = 1` asynchronously. A new burst (cmd_sram=1, cmd_addr=0x40, cmd_len=0) then writes `w_addr = 0x40` with `w_en = 0x0002`.
- **Command during busy/DONE:** `cmd_valid` held high throughout a 2-word burst → `cmd_ready = 0` in WRITE and DONE; the second command is accepted exactly at the first IDLE cycle (L+2).
